uart_receiver: RTL

- Serial receive front-end for the peripheral subsystem: samples the PC UART RX line with 16x oversampling, deframes 8N1 characters and hands each byte to the peripheral register block.
- Output is RX_DATA plus a one-cycle RX_STATUS strobe.
- Runs on the system clock, not the CPU clock; the consumer captures on the strobe.

---
 rtl/uart_receiver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial receive front-end for the peripheral subsystem. Samples the PC UART
//   RX line with 16x oversampling, deframes 8N1 characters and hands each good
//   byte to the peripheral register block together with a one-cycle strobe.
//
// Parameters:
//   DIV          sysclk cycles per oversample tick (2..65535)
//
// Ports:
//   sysclk       system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   PC_Uart_rxd  asynchronous serial line, idle high
//   RX_DATA      last correctly framed byte, LSB = first data bit
//   RX_STATUS    one-cycle pulse: RX_DATA has just been updated
//   frame_err    one-cycle pulse: stop bit was sampled low
//   rx_busy      high while a frame is in progress (any state but IDLE)

module uart_receiver #(
  parameter int DIV = 651
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       PC_Uart_rxd,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  state_t      state, state_nxt;
  logic        rxd_meta, rxd_s;
  logic [15:0] div_cnt, div_cnt_nxt;
  logic [3:0]  sample_cnt, sample_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift_reg, shift_reg_nxt;
  logic [7:0]  rx_data_nxt;
  logic        rx_status_nxt, frame_err_nxt;
  logic        tick;

  // Two-flop synchronizer for the asynchronous RX line. Both flops reset to
  // the idle (high) level so that leaving reset never looks like a start edge.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= PC_Uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // One oversample tick every DIV cycles, counted from the start edge.
  assign tick = (div_cnt == DIV_LAST);

  assign rx_busy = (state != IDLE);

  // State and datapath registers. Everything, including the output strobes,
  // is registered so RX_STATUS and frame_err appear the cycle after the
  // stop-bit sample and are exactly one cycle wide.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      RX_DATA    <= 8'h00;
      RX_STATUS  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      sample_cnt <= sample_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_reg_nxt;
      RX_DATA    <= rx_data_nxt;
      RX_STATUS  <= rx_status_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // Next-state and datapath logic. The tick divider is frozen at zero while
  // idle (or waiting for idle) so that, once a start edge is seen, tick n
  // lands exactly n*DIV cycles after it. The 4-bit sample counter wraps from
  // 15 to 0 by itself, which gives the 16-tick bit period without extra logic.
  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt;
    bit_cnt_nxt    = bit_cnt;
    shift_reg_nxt  = shift_reg;
    rx_data_nxt    = RX_DATA;
    rx_status_nxt  = 1'b0;
    frame_err_nxt  = 1'b0;

    if (state == IDLE || state == WAIT_IDLE) begin
      div_cnt_nxt = '0;
    end else if (tick) begin
      div_cnt_nxt = '0;
    end else begin
      div_cnt_nxt = div_cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_nxt      = START;
          sample_cnt_nxt = '0;
          div_cnt_nxt    = '0;
        end
      end

      // Re-check the line at the middle of the start bit; a high level there
      // means the falling edge was only a glitch.
      START: begin
        if (tick) begin
          if (sample_cnt == 4'd7) begin
            if (!rxd_s) begin
              state_nxt      = DATA;
              sample_cnt_nxt = '0;
              bit_cnt_nxt    = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            sample_cnt_nxt = sample_cnt + 4'd1;
          end
        end
      end

      // Bits arrive LSB first, so each sample enters at bit 7 and the
      // register shifts right; after eight samples bit 0 holds the first bit.
      DATA: begin
        if (tick) begin
          sample_cnt_nxt = sample_cnt + 4'd1;
          if (sample_cnt == 4'd15) begin
            shift_reg_nxt = {rxd_s, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
              state_nxt = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
      end

      // Returning to IDLE right at the stop-bit midpoint lets a back-to-back
      // start bit be caught without any idle gap.
      STOP: begin
        if (tick) begin
          sample_cnt_nxt = sample_cnt + 4'd1;
          if (sample_cnt == 4'd15) begin
            if (rxd_s) begin
              rx_data_nxt   = shift_reg;
              rx_status_nxt = 1'b1;
              state_nxt     = IDLE;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = WAIT_IDLE;
            end
          end
        end
      end

      // A break or stuck-low line parks here, so it reports a single error
      // instead of a stream of bogus frames.
      WAIT_IDLE: begin
        if (rxd_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
